// File: rtl/stream_unpacker.sv
// stream_unpacker: converts a 32-bit packed RGB video stream (four 24-bit pixels
// in three words) back into one pixel per handshake. Each pixel carries sof/eol
// flags and its x/y position.
// Optional macro STREAM_CHECK_EN adds framing checks, sticky error flags and
// SYNC recovery. Without it, tuser is used only to find the first frame start,
// and the error outputs are tied low.
module stream_unpacker #(
   parameter int X_SIZE = 1024,
   parameter int Y_SIZE = 1024
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [31:0]               in_stream_tdata,
   input  logic [3:0]                in_stream_tkeep,
   input  logic                      in_stream_tlast,
   input  logic                      in_stream_tuser,
   input  logic                      in_stream_tvalid,
   output logic                      in_stream_tready,
   output logic [7:0]                r,
   output logic [7:0]                g,
   output logic [7:0]                b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_sof,
   output logic                      out_eol,
   output logic [$clog2(X_SIZE)-1:0] x,
   output logic [$clog2(Y_SIZE)-1:0] y,
   output logic [15:0]               frame_count,
   output logic                      err_sof,
   output logic                      err_eol_early,
   output logic                      err_eol_late,
   input  logic                      err_clear
);

   localparam int WPL = 3 * X_SIZE / 4;
   localparam int XW  = $clog2(X_SIZE);
   localparam int YW  = $clog2(Y_SIZE);
   localparam int WW  = $clog2(WPL);
   localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

   typedef enum logic {SYNC, RUN} state_t;

   state_t        state_q, state_d;
   logic [47:0]   buf_q, buf_d;
   logic [2:0]    fill_q, fill_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [15:0]   frame_q, frame_d;

   logic          pix_hs;
   logic [2:0]    fill_eff;
   logic [47:0]   buf_sh;
   logic [47:0]   word_ext;
   logic          tready_c;
   logic          unused_inputs;

`ifdef STREAM_CHECK_EN
   localparam logic [WW-1:0] W_LAST = WW'(WPL - 1);
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [YW-1:0] line_q, line_d;
   logic          err_sof_q, err_sof_d;
   logic          err_early_q, err_early_d;
   logic          err_late_q, err_late_d;
   logic          sof_bad;
   logic          set_sof, set_early, set_late;

   assign unused_inputs = ^in_stream_tkeep;
   assign err_sof       = err_sof_q;
   assign err_eol_early = err_early_q;
   assign err_eol_late  = err_late_q;
`else
   assign unused_inputs = ^{in_stream_tkeep, in_stream_tlast, err_clear};
   assign err_sof       = 1'b0;
   assign err_eol_early = 1'b0;
   assign err_eol_late  = 1'b0;
`endif

   assign out_valid        = (fill_q >= 3'd3);
   assign r                = buf_q[23:16];
   assign g                = buf_q[15:8];
   assign b                = buf_q[7:0];
   assign x                = x_q;
   assign y                = y_q;
   assign out_sof          = out_valid & (x_q == '0) & (y_q == '0);
   assign out_eol          = out_valid & (x_q == X_LAST);
   assign frame_count      = frame_q;
   assign in_stream_tready = tready_c & ~areset;

   // Next state: pixel drain, word append, position counters, framing checks
   always_comb begin
      pix_hs   = out_valid & out_ready;
      fill_eff = pix_hs ? (fill_q - 3'd3) : fill_q;
      buf_sh   = pix_hs ? {24'h0, buf_q[47:24]} : buf_q;
      word_ext = {16'h0, in_stream_tdata};
      state_d  = state_q;
      buf_d    = buf_sh;
      fill_d   = fill_eff;
      x_d      = x_q;
      y_d      = y_q;
      frame_d  = frame_q;
      tready_c = 1'b0;
`ifdef STREAM_CHECK_EN
      wcnt_d    = wcnt_q;
      line_d    = line_q;
      set_sof   = 1'b0;
      set_early = 1'b0;
      set_late  = 1'b0;
      sof_bad   = in_stream_tuser & ((wcnt_q != '0) | (line_q != '0));
`endif

      if (pix_hs) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
               y_d     = '0;
               frame_d = frame_q + 16'd1;
            end else begin
               y_d = y_q + 1'b1;
            end
         end else begin
            x_d = x_q + 1'b1;
         end
      end

      case (state_q)
         SYNC: begin
            // Partial pixels left over from a broken line can never complete.
            if ((fill_q != 3'd0) && (fill_q < 3'd3)) begin
               buf_d  = '0;
               fill_d = '0;
            end
            tready_c = (fill_q == 3'd0);
            if (tready_c & in_stream_tvalid & in_stream_tuser) begin
               buf_d   = word_ext;
               fill_d  = 3'd4;
               x_d     = '0;
               y_d     = '0;
               state_d = RUN;
`ifdef STREAM_CHECK_EN
               wcnt_d  = WW'(1);
               line_d  = '0;
`endif
            end
         end
         RUN: begin
            tready_c = (fill_eff <= 3'd2);
`ifdef STREAM_CHECK_EN
            // A misplaced frame start is refused here and then accepted by SYNC.
            if (sof_bad) begin
               tready_c = 1'b0;
               if (in_stream_tvalid) begin
                  set_sof = 1'b1;
                  state_d = SYNC;
               end
            end else if (tready_c & in_stream_tvalid) begin
               if (in_stream_tlast != (wcnt_q == W_LAST)) begin
                  set_early = in_stream_tlast;
                  set_late  = ~in_stream_tlast;
                  state_d   = SYNC;
               end else begin
                  buf_d  = buf_sh | (word_ext << {fill_eff, 3'b000});
                  fill_d = fill_eff + 3'd4;
                  if (wcnt_q == W_LAST) begin
                     wcnt_d = '0;
                     line_d = (line_q == Y_LAST) ? '0 : line_q + 1'b1;
                  end else begin
                     wcnt_d = wcnt_q + 1'b1;
                  end
               end
            end
`else
            if (tready_c & in_stream_tvalid) begin
               buf_d  = buf_sh | (word_ext << {fill_eff, 3'b000});
               fill_d = fill_eff + 3'd4;
            end
`endif
         end
         default: ;
      endcase

`ifdef STREAM_CHECK_EN
      err_sof_d   = set_sof   | (err_sof_q   & ~err_clear);
      err_early_d = set_early | (err_early_q & ~err_clear);
      err_late_d  = set_late  | (err_late_q  & ~err_clear);
`endif
   end

   // State registers, cleared asynchronously
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q     <= SYNC;
         buf_q       <= '0;
         fill_q      <= '0;
         x_q         <= '0;
         y_q         <= '0;
         frame_q     <= '0;
`ifdef STREAM_CHECK_EN
         wcnt_q      <= '0;
         line_q      <= '0;
         err_sof_q   <= 1'b0;
         err_early_q <= 1'b0;
         err_late_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         fill_q      <= fill_d;
         x_q         <= x_d;
         y_q         <= y_d;
         frame_q     <= frame_d;
`ifdef STREAM_CHECK_EN
         wcnt_q      <= wcnt_d;
         line_q      <= line_d;
         err_sof_q   <= err_sof_d;
         err_early_q <= err_early_d;
         err_late_q  <= err_late_d;
`endif
      end
   end

endmodule

// File: tb/tb_stream_unpacker.sv
// tb_stream_unpacker: scoreboard bench for stream_unpacker with X_SIZE=8, Y_SIZE=2.
// The stimulus pushes the expected pixels into a queue. The monitor compares every
// presented pixel against the head of that queue, and pops the head on handshake.
module tb_stream_unpacker;
   localparam int XS = 8;
   localparam int YS = 2;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic [2:0] x;
      logic       y;
      logic       sof;
      logic       eol;
   } pix_t;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [31:0] in_stream_tdata = '0;
   logic [3:0]  in_stream_tkeep = 4'hF;
   logic        in_stream_tlast = 1'b0;
   logic        in_stream_tuser = 1'b0;
   logic        in_stream_tvalid = 1'b0;
   logic        in_stream_tready;
   logic [7:0]  r, g, b;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_sof, out_eol;
   logic [2:0]  x;
   logic        y;
   logic [15:0] frame_count;
   logic        err_sof, err_eol_early, err_eol_late;
   logic        err_clear = 1'b0;

   int   tests = 0;
   int   errors = 0;
   logic toggle_mode = 1'b0;
   pix_t exp_q[$];
   pix_t got;

   always #5 aclk = ~aclk;

   stream_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
      .aclk(aclk), .areset(areset),
      .in_stream_tdata(in_stream_tdata), .in_stream_tkeep(in_stream_tkeep),
      .in_stream_tlast(in_stream_tlast), .in_stream_tuser(in_stream_tuser),
      .in_stream_tvalid(in_stream_tvalid), .in_stream_tready(in_stream_tready),
      .r(r), .g(g), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .out_sof(out_sof), .out_eol(out_eol), .x(x), .y(y),
      .frame_count(frame_count), .err_sof(err_sof),
      .err_eol_early(err_eol_early), .err_eol_late(err_eol_late),
      .err_clear(err_clear)
   );

   // Downstream ready: constant high, or toggling every cycle
   always @(posedge aclk) begin
      #1;
      out_ready = toggle_mode ? ~out_ready : 1'b1;
   end

   // Monitor: every presented pixel must equal the queue head (including stalls)
   always @(negedge aclk) begin
      if (!areset && out_valid) begin
         tests++;
         got = {r, g, b, x, y, out_sof, out_eol};
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pixel_unexpected: got rgb=%h%h%h x=%0d y=%0d, required no pixel",
                     r, g, b, x, y);
         end else begin
            if (got !== exp_q[0]) begin
               errors++;
               $display("FAIL pixel: got rgb=%h%h%h x=%0d y=%0d sof=%b eol=%b, required rgb=%h%h%h x=%0d y=%0d sof=%b eol=%b",
                        r, g, b, x, y, out_sof, out_eol,
                        exp_q[0].r, exp_q[0].g, exp_q[0].b, exp_q[0].x, exp_q[0].y,
                        exp_q[0].sof, exp_q[0].eol);
            end
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Word k of a frame whose pixel n is {n+off, n+off+1, n+off+2}
   function automatic logic [31:0] frame_word(input int off, input int k);
      logic [31:0] w;
      int          idx;
      w = '0;
      for (int j = 0; j < 4; j++) begin
         idx = 4 * k + j;
         w[8*j +: 8] = 8'(idx / 3 + off + 2 - idx % 3);
      end
      return w;
   endfunction

   task automatic push_pix(input int off, input int n);
      pix_t p;
      p.r   = 8'(n + off);
      p.g   = 8'(n + off + 1);
      p.b   = 8'(n + off + 2);
      p.x   = 3'(n % XS);
      p.y   = 1'((n / XS) % YS);
      p.sof = ((n % (XS * YS)) == 0);
      p.eol = ((n % XS) == XS - 1);
      exp_q.push_back(p);
   endtask

   task automatic send_word(input logic [31:0] d, input logic u, input logic l);
      logic rdy;
      in_stream_tdata  = d;
      in_stream_tuser  = u;
      in_stream_tlast  = l;
      in_stream_tvalid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge aclk);
         rdy = in_stream_tready;
         @(posedge aclk);
         #1;
         if (rdy) break;
         if (i == 399) begin
            tests++;
            errors++;
            $display("FAIL word_accept: got no tready for word %h, required accept", d);
         end
      end
      in_stream_tvalid = 1'b0;
      in_stream_tuser  = 1'b0;
      in_stream_tlast  = 1'b0;
   endtask

   task automatic send_frame(input int off, input int bad_last);
      for (int n = 0; n < XS * YS; n++) push_pix(off, n);
      for (int k = 0; k < 12; k++)
         send_word(frame_word(off, k), (k == 0), ((k % 6) == 5) || (k == bad_last));
   endtask

   task automatic wait_drain(input string name);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < 1000) begin
         @(posedge aclk);
         i++;
      end
      tests++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: got %0d pixels still pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      @(posedge aclk);
      #1;
      err_clear = 1'b0;
   endtask

   function automatic logic [63:0] outs_vec();
      return {13'h0, r, g, b, x, y, out_valid, out_sof, out_eol, in_stream_tready,
              frame_count, err_sof, err_eol_early, err_eol_late};
   endfunction

   initial begin
      #1;
      check("reset_state", outs_vec(), 64'h0);
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0;

      // Well-formed frame at full rate
      send_frame(8'h00, -1);
      wait_drain("frame1_drain");
      check("frame1_count", frame_count, 1);
      check("frame1_errors", {err_sof, err_eol_early, err_eol_late}, 0);

      // Same framing with downstream stalling every other cycle
      toggle_mode = 1'b1;
      send_frame(8'h20, -1);
      wait_drain("frame2_drain");
      toggle_mode = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      check("frame2_count", frame_count, 2);

      // Reset mid-line after two words (fill = 5)
      push_pix(8'h40, 0);
      send_word(frame_word(8'h40, 0), 1'b1, 1'b0);
      send_word(frame_word(8'h40, 1), 1'b0, 1'b0);
      areset = 1'b1;
      #1;
      check("reset_mid_outputs", outs_vec(), 64'h0);
      check("reset_mid_pending", exp_q.size(), 0);
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0;

      // Leading words without tuser are discarded
      send_word(32'h11223344, 1'b0, 1'b0);
      send_word(32'h55667788, 1'b0, 1'b1);
      send_word(32'h99AABBCC, 1'b0, 1'b0);
      send_frame(8'h60, -1);
      wait_drain("lead_drain");
      check("lead_count", frame_count, 1);

`ifdef STREAM_CHECK_EN
      // Early tlast on word 3 of line 0
      for (int n = 0; n < 4; n++) push_pix(8'h80, n);
      send_word(frame_word(8'h80, 0), 1'b1, 1'b0);
      send_word(frame_word(8'h80, 1), 1'b0, 1'b0);
      send_word(frame_word(8'h80, 2), 1'b0, 1'b0);
      send_word(frame_word(8'h80, 3), 1'b0, 1'b1);
      send_word(32'hDEADBEEF, 1'b0, 1'b0);
      send_word(32'h0BADF00D, 1'b0, 1'b1);
      send_frame(8'h90, -1);
      wait_drain("early_drain");
      check("early_errors", {err_sof, err_eol_early, err_eol_late}, 3'b010);
      check("early_count", frame_count, 2);
      pulse_clear();
      check("early_clear", {err_sof, err_eol_early, err_eol_late}, 3'b000);

      // tuser on word 2 of line 1 restarts the frame
      for (int n = 0; n < 10; n++) push_pix(8'hA0, n);
      for (int k = 0; k < 8; k++)
         send_word(frame_word(8'hA0, k), (k == 0), (k == 5));
      send_frame(8'hB0, -1);
      wait_drain("sof_drain");
      check("sof_errors", {err_sof, err_eol_early, err_eol_late}, 3'b100);
      check("sof_count", frame_count, 3);
      pulse_clear();
      check("sof_clear", err_sof, 0);
`else
      // Misplaced tlast is ignored once running
      send_frame(8'hD0, 3);
      wait_drain("nocheck_drain");
      check("nocheck_count", frame_count, 2);
      check("nocheck_errors", {err_sof, err_eol_early, err_eol_late}, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
